// File: rtl/modulo_conversor_bcd_display_7_bits.sv
// 7-bit binary to 3-digit BCD converter (sequential double-dabble, start/busy/done)
// driving a multiplexed 3-digit 7-segment display with leading-zero blanking.
module modulo_conversor_bcd_display_7_bits #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [6:0]  bin_in,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd_out,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    // Handshake: start is level-sampled and only accepted in S_IDLE; busy is high
    // for the 7 shift cycles; done pulses for one cycle once bcd_out holds the result.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t        r_state;
    logic [18:0]   r_shift;
    logic [2:0]    r_step;
    logic          r_busy;
    logic          r_done;
    logic [11:0]   r_bcd;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_digit;

    logic [18:0]   w_adj;
    logic [18:0]   w_shifted;
    logic [3:0]    w_sel;
    logic          w_blank;
    logic [2:0]    w_an;

    // Register layout is {H[18:15], T[14:11], U[10:7], bin[6:0]}.
    always_comb begin
        w_adj = r_shift;
        for (int i = 0; i < 3; i++) begin
            if (r_shift[7+4*i +: 4] >= 4'd5)
                w_adj[7+4*i +: 4] = r_shift[7+4*i +: 4] + 4'd3;
        end
        w_shifted = w_adj << 1;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_step  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_shift <= {12'h000, bin_in};
                        r_step  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_shift <= w_shifted;
                    r_step  <= r_step + 3'd1;
                    if (r_step == 3'd6) begin
                        r_bcd   <= w_shifted[18:7];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Scan runs freely, independent of the converter.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_presc <= '0;
            r_digit <= '0;
        end else if (r_presc == PW'(SCAN_DIV - 1)) begin
            r_presc <= '0;
            r_digit <= (r_digit == 2'd2) ? 2'd0 : r_digit + 2'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    always_comb begin
        w_an    = 3'b110;
        w_sel   = r_bcd[3:0];
        w_blank = 1'b0;
        case (r_digit)
            2'd1: begin
                w_an    = 3'b101;
                w_sel   = r_bcd[7:4];
                w_blank = (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
            end
            2'd2: begin
                w_an    = 3'b011;
                w_sel   = r_bcd[11:8];
                w_blank = (r_bcd[11:8] == 4'd0);
            end
            default: begin
                w_an    = 3'b110;
                w_sel   = r_bcd[3:0];
                w_blank = 1'b0;
            end
        endcase
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bcd_out = r_bcd;
    assign an      = w_an;
    assign seg     = w_blank ? 7'h00 : seg_decode(w_sel);

endmodule

// File: tb/tb_modulo_conversor_bcd_display_7_bits.sv
// Directed bench for the BCD converter/display: reset, boundaries, handshake,
// abort and a full 0..127 sweep against a decimal model, plus display scan checks.
module tb_modulo_conversor_bcd_display_7_bits;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [6:0]  bin_in = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;
    logic [6:0]  seg;
    logic [2:0]  an;

    int n_pass   = 0;
    int n_total  = 0;
    int n_fail   = 0;
    int n_accept = 0;
    int done_cnt = 0;
    logic [11:0] exp_q[$];

    modulo_conversor_bcd_display_7_bits #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk     (clk),
        .clr     (clr),
        .bin_in  (bin_in),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] gold_bcd(input int v);
        gold_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        seg_of = (d < 4'd10) ? tbl[d] : 7'h00;
    endfunction

    // Wait for done after an accept; reports latency (edges after accept) and busy cycles.
    task automatic wait_done(output int cyc, output int bc);
        bit got;
        got = 0;
        cyc = 0;
        bc  = (busy === 1'b1) ? 1 : 0;
        while (!got && cyc < 20) begin
            tick;
            cyc++;
            if (done === 1'b1) got = 1;
            else if (busy === 1'b1) bc++;
        end
    endtask

    task automatic run_conv(input int v, input string tag);
        int cyc;
        int bc;
        logic [11:0] e;
        bin_in = 7'(v);
        start  = 1'b1;
        exp_q.push_back(gold_bcd(v));
        n_accept++;
        tick;
        start = 1'b0;
        wait_done(cyc, bc);
        chk({tag, "_latency"}, cyc, 7);
        chk({tag, "_busy_cycles"}, bc, 7);
        e = exp_q.pop_front();
        chk({tag, "_bcd"}, {20'h0, bcd_out}, {20'h0, e});
        tick;
        chk({tag, "_done_pulse"}, {31'h0, done}, 0);
    endtask

    task automatic check_scan(input logic [11:0] b, input string tag);
        logic [2:0] an_exp;
        logic [6:0] seg_exp;
        int cnt;
        for (int d = 0; d < 3; d++) begin
            an_exp  = (d == 0) ? 3'b110 : (d == 1) ? 3'b101 : 3'b011;
            seg_exp = seg_of(b[4*d +: 4]);
            if (d == 2 && b[11:8] == 4'd0) seg_exp = 7'h00;
            if (d == 1 && b[11:8] == 4'd0 && b[7:4] == 4'd0) seg_exp = 7'h00;
            cnt = 0;
            while (an !== an_exp && cnt < 3 * SCAN_DIV + 2) begin
                tick;
                cnt++;
            end
            chk($sformatf("%s_an%0d", tag, d), {29'h0, an}, {29'h0, an_exp});
            chk($sformatf("%s_seg%0d", tag, d), {25'h0, seg}, {25'h0, seg_exp});
        end
    endtask

    initial begin
        int cyc;
        int bc;
        int snap;
        logic [11:0] e;

        // Asynchronous reset mid-cycle
        tick;
        tick;
        #3 clr = 1'b0;
        #1;
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_bcd", {20'h0, bcd_out}, 0);
        chk("rst_an", {29'h0, an}, 3'b110);
        chk("rst_seg", {25'h0, seg}, 7'h3F);
        @(negedge clk) clr = 1'b1;
        tick;

        // Full-scale value and its display
        run_conv(127, "conv127");
        check_scan(12'h127, "scan127");

        // Boundaries
        run_conv(0, "conv0");
        check_scan(12'h000, "scan0");
        run_conv(9, "conv9");
        check_scan(12'h009, "scan9");
        run_conv(10, "conv10");
        check_scan(12'h010, "scan10");
        run_conv(100, "conv100");
        check_scan(12'h100, "scan100");

        // Held start, bin_in changed during conversion
        bin_in = 7'd45;
        start  = 1'b1;
        exp_q.push_back(gold_bcd(45));
        n_accept++;
        tick;
        bin_in = 7'd99;
        wait_done(cyc, bc);
        chk("hold_first_latency", cyc, 7);
        e = exp_q.pop_front();
        chk("hold_first_bcd", {20'h0, bcd_out}, {20'h0, e});
        exp_q.push_back(gold_bcd(99));
        n_accept++;
        tick;
        chk("hold_idle_gap", {31'h0, busy}, 0);
        tick;
        chk("hold_reaccept_busy", {31'h0, busy}, 1);
        start = 1'b0;
        wait_done(cyc, bc);
        chk("hold_second_latency", cyc, 7);
        e = exp_q.pop_front();
        chk("hold_second_bcd", {20'h0, bcd_out}, {20'h0, e});
        tick;

        // Abort mid-conversion
        bin_in = 7'd88;
        start  = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        #3 clr = 1'b0;
        #1;
        snap = done_cnt;
        chk("abort_busy", {31'h0, busy}, 0);
        chk("abort_done", {31'h0, done}, 0);
        chk("abort_bcd", {20'h0, bcd_out}, 0);
        chk("abort_an", {29'h0, an}, 3'b110);
        chk("abort_seg", {25'h0, seg}, 7'h3F);
        repeat (3) tick;
        @(negedge clk) clr = 1'b1;
        repeat (10) tick;
        chk("abort_no_done", done_cnt, snap);
        chk("abort_bcd_hold", {20'h0, bcd_out}, 0);
        run_conv(64, "conv64");

        // Exhaustive sweep with random gaps between requests
        for (int v = 0; v < 128; v++) begin
            run_conv(v, $sformatf("sweep%0d", v));
            repeat ($urandom_range(0, 2)) tick;
        end

        tick;
        chk("queue_empty", exp_q.size(), 0);
        chk("done_count", done_cnt, n_accept);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
